// File: rtl/button_debounce_if.sv
// Button bundle between the raw pins and the debounced consumers.
// master drives the pins (board / bench); slave is the conditioner.
interface button_debounce_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_long;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_long
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_long
    );
endinterface

// File: rtl/button_debounce.sv
// Push-button conditioner: per-channel two-flop synchroniser, stability-counter
// debounce and saturating long-press timer; every output comes straight from a flop.
//
// state     | meaning
// STABLE_LO | debounced level low; deb_cnt counts consecutive high samples
// STABLE_HI | debounced level high; deb_cnt counts consecutive low samples, hold_cnt times the press
module button_debounce #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 50000000
) (
    input  logic             clk,
    input  logic             reset,
    button_debounce_if.slave btn
);
    // deb_cnt tops out at DEBOUNCE_CYCLES-1, hold_cnt at HOLD_CYCLES
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic {
        STABLE_LO = 1'b0,
        STABLE_HI = 1'b1
    } state_t;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic              sync1;
        logic              sync2;
        logic              long_q;
        state_t            state;
        logic [DEB_W-1:0]  deb_cnt;
        logic [HOLD_W-1:0] hold_cnt;
        logic              differ;
        logic              settle;

        assign differ = sync2 != (state == STABLE_HI);
        assign settle = differ && (deb_cnt == DEB_LAST);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync1    <= 1'b0;
                sync2    <= 1'b0;
                state    <= STABLE_LO;
                deb_cnt  <= '0;
                hold_cnt <= '0;
                long_q   <= 1'b0;
            end else begin
                sync1 <= btn.btn_raw[i];
                sync2 <= sync1;
                // clears on a matching sample and on the accepting edge itself
                deb_cnt <= (differ && !settle) ? deb_cnt + 1'b1 : '0;
                case (state)
                    STABLE_LO: begin
                        hold_cnt <= '0;
                        long_q   <= 1'b0;
                        if (settle) state <= STABLE_HI;
                    end
                    STABLE_HI: begin
                        if (settle) begin
                            state    <= STABLE_LO;
                            hold_cnt <= '0;
                            long_q   <= 1'b0;
                        end else if (hold_cnt != HOLD_MAX) begin
                            hold_cnt <= hold_cnt + 1'b1;
                            if (hold_cnt == HOLD_PRE) long_q <= 1'b1;
                        end
                    end
                    default: state <= STABLE_LO;
                endcase
            end
        end

        assign btn.btn_level[i] = (state == STABLE_HI);
        assign btn.btn_long[i]  = long_q;
    end
endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: a sample-history reference model feeds
// an expectation queue that an independent monitor drains every clock edge.
module tb_button_debounce;
    localparam int NB   = 2;
    localparam int DEB  = 4;
    localparam int HOLD = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests   = 0;
    int   fails   = 0;
    int   edge_no = 0;

    button_debounce_if #(.N_BTN(NB)) bif ();

    button_debounce #(
        .N_BTN          (NB),
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .btn  (bif.slave)
    );

    always #5 clk = ~clk;

    // expected {btn_level, btn_long} after each edge
    logic [2*NB-1:0] exp_q[$];

    // reference model: raw samples per channel, oldest first
    bit samp[NB][$];
    bit m_lvl[NB];
    bit m_long[NB];
    int m_run[NB];

    int lvl_rise_edge[NB];
    int lvl_rise_cnt[NB];
    int lvl_fall_edge[NB];
    int long_rise_edge[NB];
    int long_rise_cnt[NB];
    int long_fall_edge[NB];
    logic [NB-1:0] prev_lvl;
    logic [NB-1:0] prev_long;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NB; c++) begin
            samp[c].delete();
            samp[c].push_back(1'b0);
            samp[c].push_back(1'b0);
            m_lvl[c]  = 1'b0;
            m_long[c] = 1'b0;
            m_run[c]  = 0;
        end
        exp_q.delete();
    endfunction

    // Level flips once the DEB most recent synchronised samples (two edges old)
    // all disagree with it; long asserts HOLD edges after the level went high.
    function automatic void model_step(input logic [NB-1:0] v);
        logic [2*NB-1:0] e;
        for (int c = 0; c < NB; c++) begin
            int n;
            bit flip;
            samp[c].push_back(v[c]);
            n = samp[c].size();
            flip = (n >= DEB + 2);
            if (flip) begin
                for (int j = 0; j < DEB; j++)
                    if (samp[c][n-3-j] == m_lvl[c]) flip = 1'b0;
            end
            if (flip) begin
                m_lvl[c] = !m_lvl[c];
                m_run[c] = 0;
            end else if (m_lvl[c]) begin
                m_run[c]++;
            end
            m_long[c] = m_lvl[c] && (m_run[c] >= HOLD);
            while (samp[c].size() > DEB + 3) void'(samp[c].pop_front());
        end
        for (int c = 0; c < NB; c++) begin
            e[NB+c] = m_lvl[c];
            e[c]    = m_long[c];
        end
        exp_q.push_back(e);
    endfunction

    task automatic drive(input logic [NB-1:0] v, input bit rel = 1'b0);
        @(negedge clk);
        if (rel) begin
            reset = 1'b0;
            model_reset();
        end
        bif.btn_raw = v;
        model_step(v);
    endtask

    // monitor: pops one expectation per edge and logs output transitions
    initial begin
        logic [2*NB-1:0] e;
        prev_lvl  = '0;
        prev_long = '0;
        for (int c = 0; c < NB; c++) begin
            lvl_rise_edge[c] = 0;  lvl_rise_cnt[c]  = 0;  lvl_fall_edge[c]  = 0;
            long_rise_edge[c] = 0; long_rise_cnt[c] = 0;  long_fall_edge[c] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            edge_no++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_level", int'(bif.btn_level), int'(e[2*NB-1:NB]));
                check("sb_long", int'(bif.btn_long), int'(e[NB-1:0]));
            end
            for (int c = 0; c < NB; c++) begin
                if (bif.btn_level[c] && !prev_lvl[c]) begin
                    lvl_rise_edge[c] = edge_no;
                    lvl_rise_cnt[c]++;
                end
                if (!bif.btn_level[c] && prev_lvl[c]) lvl_fall_edge[c] = edge_no;
                if (bif.btn_long[c] && !prev_long[c]) begin
                    long_rise_edge[c] = edge_no;
                    long_rise_cnt[c]++;
                end
                if (!bif.btn_long[c] && prev_long[c]) long_fall_edge[c] = edge_no;
            end
            prev_lvl  = bif.btn_level;
            prev_long = bif.btn_long;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish before 1 ms");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int base;
        int rc;
        int lc;
        int rem[NB];
        logic [NB-1:0] cur;

        bif.btn_raw = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_level", int'(bif.btn_level), 0);
        check("reset_long", int'(bif.btn_long), 0);

        // clean press on channel 0
        drive(2'b01, 1'b1);
        base = edge_no;
        repeat (19) drive(2'b01);
        check("press_level_edge", lvl_rise_edge[0] - base, 6);
        check("press_long_edge", long_rise_edge[0] - base, 16);
        check("press_ch1_level_quiet", lvl_rise_cnt[1], 0);
        check("press_ch1_long_quiet", long_rise_cnt[1], 0);

        // 3-cycle low glitch is rejected, then a real release
        repeat (3) drive(2'b00);
        repeat (6) drive(2'b01);
        check("glitch_keeps_level", int'(bif.btn_level[0]), 1);
        check("glitch_keeps_long", int'(bif.btn_long[0]), 1);
        drive(2'b00);
        base = edge_no;
        repeat (9) drive(2'b00);
        check("release_level_edge", lvl_fall_edge[0] - base, 6);
        check("release_long_edge", long_fall_edge[0] - base, 6);

        // bounce: 1x3, 0x1, 1x2, 0x2, then steady
        rc = lvl_rise_cnt[0];
        repeat (3) drive(2'b01);
        drive(2'b00);
        repeat (2) drive(2'b01);
        repeat (2) drive(2'b00);
        drive(2'b01);
        base = edge_no;
        repeat (11) drive(2'b01);
        check("bounce_rise_count", lvl_rise_cnt[0] - rc, 1);
        check("bounce_rise_edge", lvl_rise_edge[0] - base, 6);

        // staggered channels, channel 0 released mid-hold
        repeat (10) drive(2'b00);
        lc = long_rise_cnt[0];
        drive(2'b01);
        base = edge_no;
        drive(2'b01);
        repeat (7) drive(2'b11);
        repeat (16) drive(2'b10);
        check("stagger_level_gap", lvl_rise_edge[1] - lvl_rise_edge[0], 2);
        check("stagger_ch0_fall", lvl_fall_edge[0] - base, 15);
        check("stagger_ch0_no_long", long_rise_cnt[0] - lc, 0);
        check("stagger_ch1_long", long_rise_edge[1] - base, 18);

        // asynchronous reset with both buttons held
        repeat (8) drive(2'b11);
        check("pre_reset_level", int'(bif.btn_level), 3);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_level", int'(bif.btn_level), 0);
        check("async_reset_long", int'(bif.btn_long), 0);
        repeat (2) @(posedge clk);
        drive(2'b11, 1'b1);
        base = edge_no;
        repeat (19) drive(2'b11);
        check("post_reset_level0", lvl_rise_edge[0] - base, 6);
        check("post_reset_level1", lvl_rise_edge[1] - base, 6);
        check("post_reset_long0", long_rise_edge[0] - base, 16);
        check("post_reset_long1", long_rise_edge[1] - base, 16);

        // random runs: mostly short glitches around the debounce window, some long holds
        cur = 2'b11;
        for (int c = 0; c < NB; c++) rem[c] = 0;
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < NB; c++) begin
                if (rem[c] == 0) begin
                    cur[c] = ~cur[c];
                    rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 25))
                                                          : int'($urandom_range(1, 6));
                end
                rem[c]--;
            end
            drive(cur);
        end
        @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
